// File: rtl/mem_read_arbiter.sv
// Two-requester AXI read arbiter (m0 = i_cache, m1 = d_cache) onto one memory read port, one burst at a time.
// Define MEM_READ_ARB_RR_EN for round-robin arbitration; otherwise m1 has fixed priority.
module mem_read_arbiter #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [LEN_WIDTH-1:0]  m0_arlen,
    input  logic [ID_WIDTH-1:0]   m0_arid,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [LEN_WIDTH-1:0]  m1_arlen,
    input  logic [ID_WIDTH-1:0]   m1_arid,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [ADDR_WIDTH-1:0] mem_araddr,
    output logic [LEN_WIDTH-1:0]  mem_arlen,
    output logic [ID_WIDTH-1:0]   mem_arid,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  grant_q;      // 1 = m1, 0 = m0
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_cnt_q;
    logic                  pick_m1;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [LEN_WIDTH-1:0]  len_d;
    logic [ADDR_WIDTH-1:0] g_araddr;
    logic [LEN_WIDTH-1:0]  g_arlen;
    logic [ID_WIDTH-1:0]   g_arid;
    logic                  g_arvalid;
    logic                  g_rready;
    logic                  ar_hs;
    logic                  beat_acc;
    logic                  beat_last;

`ifdef MEM_READ_ARB_RR_EN
    logic                  rr_last_q;    // 1 = m1 served last

    // On a simultaneous request, favour the port not served last.
    assign pick_m1 = m1_arvalid & (~m0_arvalid | ~rr_last_q);
`else
    assign pick_m1 = m1_arvalid;
`endif

    assign sel_len   = pick_m1 ? m1_arlen : m0_arlen;
    assign len_d     = (sel_len == '0) ? LEN_WIDTH'(1) : sel_len;

    assign g_araddr  = grant_q ? m1_araddr  : m0_araddr;
    assign g_arlen   = grant_q ? m1_arlen   : m0_arlen;
    assign g_arid    = grant_q ? m1_arid    : m0_arid;
    assign g_arvalid = grant_q ? m1_arvalid : m0_arvalid;
    assign g_rready  = grant_q ? m1_rready  : m0_rready;

    assign ar_hs     = (state_q == ADDR) & g_arvalid & mem_arready;
    assign beat_acc  = (state_q == DATA) & mem_rvalid & g_rready;
    assign beat_last = beat_acc & (beat_cnt_q == len_q - LEN_WIDTH'(1));

    // Read data is fanned out; only the granted rvalid qualifies it.
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_araddr  = '0;
        mem_arlen   = '0;
        mem_arid    = '0;
        mem_arvalid = 1'b0;
        m0_arready  = 1'b0;
        m1_arready  = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        mem_rready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_arvalid | m1_arvalid) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                mem_araddr  = g_araddr;
                mem_arlen   = g_arlen;
                mem_arid    = g_arid;
                mem_arvalid = g_arvalid;
                m0_arready  = ~grant_q & mem_arready;
                m1_arready  = grant_q & mem_arready;
                if (ar_hs) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m0_rvalid  = ~grant_q & mem_rvalid;
                m1_rvalid  = grant_q & mem_rvalid;
                mem_rready = g_rready;
                if (beat_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant, burst length and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= 1'b1;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            if ((state_q == IDLE) && (m0_arvalid | m1_arvalid)) begin
                grant_q <= pick_m1;
                len_q   <= len_d;
            end
            if (ar_hs) begin
                beat_cnt_q <= '0;
            end else if (beat_acc && !beat_last) begin
                beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
            end
        end
    end

`ifdef MEM_READ_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 1'b0;
        end else if (beat_last) begin
            rr_last_q <= grant_q;
        end
    end
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed scenarios plus randomized bursts against a
// transaction-level model (grant choice, field forwarding, beat count, routing).
module tb_mem_read_arbiter;

    localparam int unsigned AW = 26;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr_m   [2];
    logic [LW-1:0] len_m    [2];
    logic [IW-1:0] id_m     [2];
    logic          req_m    [2];
    logic          rready_m [2];
    logic          arready_m[2];
    logic [DW-1:0] rdata_m  [2];
    logic          rvalid_m [2];
    logic [AW-1:0] mem_araddr;
    logic [LW-1:0] mem_arlen;
    logic [IW-1:0] mem_arid;
    logic          mem_arvalid;
    logic          mem_arready;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic          mem_rready;
    logic          busy;

    int errors = 0;
    int checks = 0;
    bit dir_data = 1'b0;
`ifdef MEM_READ_ARB_RR_EN
    bit rr_last_m = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_read_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_araddr(addr_m[0]), .m0_arlen(len_m[0]), .m0_arid(id_m[0]), .m0_arvalid(req_m[0]),
        .m0_arready(arready_m[0]), .m0_rdata(rdata_m[0]), .m0_rvalid(rvalid_m[0]), .m0_rready(rready_m[0]),
        .m1_araddr(addr_m[1]), .m1_arlen(len_m[1]), .m1_arid(id_m[1]), .m1_arvalid(req_m[1]),
        .m1_arready(arready_m[1]), .m1_rdata(rdata_m[1]), .m1_rvalid(rvalid_m[1]), .m1_rready(rready_m[1]),
        .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arid(mem_arid), .mem_arvalid(mem_arvalid),
        .mem_arready(mem_arready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model arbitration: which port wins given the current requests (1 = m1).
    function automatic bit pick(input bit v0, input bit v1);
`ifdef MEM_READ_ARB_RR_EN
        if (v0 && v1) return !rr_last_m;
`endif
        return v1;
    endfunction

    task automatic set_req(input int p, input int unsigned a, input int unsigned l, input int unsigned id);
        addr_m[p] = AW'(a);
        len_m[p]  = LW'(l);
        id_m[p]   = IW'(id);
        req_m[p]  = 1'b1;
    endtask

    // Serve one burst starting from IDLE; abort_at > 0 pulses reset after that many accepted beats.
    task automatic serve(input int ar_stall, input bit rstall, input int abort_at);
        bit w;
        int o;
        int nb;
        int acc;
        int cyc;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_arvalid", 64'(mem_arvalid), 64'd0);
        chk("idle_arready", {62'd0, arready_m[1], arready_m[0]}, 64'd0);
        w  = pick(req_m[0], req_m[1]);
        o  = w ? 0 : 1;
        nb = (len_m[w] == 0) ? 1 : int'(len_m[w]);
        for (int i = 0; i <= ar_stall; i++) begin
            @(negedge clk);
            mem_arready = (i == ar_stall);
            #1;
            chk("ar_valid", 64'(mem_arvalid), 64'd1);
            chk("ar_addr", 64'(mem_araddr), 64'(addr_m[w]));
            chk("ar_len", 64'(mem_arlen), 64'(len_m[w]));
            chk("ar_id", 64'(mem_arid), 64'(id_m[w]));
            chk("ar_ready_win", 64'(arready_m[w]), 64'(mem_arready));
            chk("ar_ready_lose", 64'(arready_m[o]), 64'd0);
            chk("ar_busy", 64'(busy), 64'd1);
        end
        @(negedge clk);
        req_m[w]    = 1'b0;
        mem_arready = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < nb && cyc < 300) begin
            if (abort_at > 0 && acc == abort_at) begin
                rst_n       = 1'b0;
                mem_rvalid  = 1'b1;
                mem_arready = 1'b1;
                rready_m[0] = 1'b1;
                rready_m[1] = 1'b1;
                req_m[0]    = 1'b0;
                req_m[1]    = 1'b0;
                #1;
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_ar", {mem_araddr, mem_arlen, mem_arid, mem_arvalid}, 64'd0);
                chk("rst_rready", 64'(mem_rready), 64'd0);
                chk("rst_rvalid", {62'd0, rvalid_m[1], rvalid_m[0]}, 64'd0);
                chk("rst_arready", {62'd0, arready_m[1], arready_m[0]}, 64'd0);
`ifdef MEM_READ_ARB_RR_EN
                rr_last_m = 1'b0;
`endif
                @(negedge clk);
                rst_n       = 1'b1;
                mem_rvalid  = 1'b0;
                mem_arready = 1'b0;
                return;
            end
            if (dir_data) begin
                mem_rvalid  = 1'b1;
                mem_rdata   = DW'(32'hA0) + DW'(acc);
                rready_m[w] = 1'b1;
            end else begin
                mem_rvalid  = ($urandom_range(3) != 0);
                mem_rdata   = DW'($urandom);
                rready_m[w] = ($urandom_range(3) != 0);
            end
            if (rstall && cyc >= 1 && cyc <= 3) rready_m[w] = 1'b0;
            rready_m[o] = 1'($urandom_range(1));
            #1;
            chk("d_rvalid_win", 64'(rvalid_m[w]), 64'(mem_rvalid));
            chk("d_rvalid_lose", 64'(rvalid_m[o]), 64'd0);
            chk("d_rready", 64'(mem_rready), 64'(rready_m[w]));
            chk("d_rdata", 64'(rdata_m[w]), 64'(mem_rdata));
            chk("d_busy", 64'(busy), 64'd1);
            chk("d_arvalid", 64'(mem_arvalid), 64'd0);
            if (mem_rvalid && rready_m[w]) acc++;
            cyc++;
            @(negedge clk);
        end
        chk("beats", 64'(acc), 64'(nb));
        mem_rvalid = 1'b1;
        #1;
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_stray_rready", 64'(mem_rready), 64'd0);
        chk("end_rvalid", {62'd0, rvalid_m[1], rvalid_m[0]}, 64'd0);
        mem_rvalid = 1'b0;
`ifdef MEM_READ_ARB_RR_EN
        rr_last_m = w;
`endif
    endtask

    initial begin
        rst_n       = 1'b0;
        mem_arready = 1'b0;
        mem_rdata   = '0;
        mem_rvalid  = 1'b0;
        for (int p = 0; p < 2; p++) begin
            addr_m[p] = '0; len_m[p] = '0; id_m[p] = '0; req_m[p] = 1'b0; rready_m[p] = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ar", {mem_araddr, mem_arlen, mem_arid, mem_arvalid}, 64'd0);
        chk("reset_rready", 64'(mem_rready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single d_cache refill with fixed data pattern
        @(negedge clk);
        dir_data = 1'b1;
        set_req(1, 32'h100, 4, 8);
        #1;
        serve(0, 1'b0, 0);
        dir_data = 1'b0;

        // Simultaneous requests, then m1 re-raises while m0 is still pending
        @(negedge clk);
        set_req(0, 32'h2000, 2, 1);
        set_req(1, 32'h3000, 3, 8);
        #1;
        serve(0, 1'b0, 0);
        if (!req_m[1]) set_req(1, 32'h3040, 2, 9);
        if (!req_m[0]) set_req(0, 32'h2040, 2, 2);
        while (req_m[0] || req_m[1]) serve(0, 1'b0, 0);

        // Address stall of five cycles
        @(negedge clk);
        set_req(1, 32'h1234, 4, 8);
        #1;
        serve(5, 1'b0, 0);

        // Requester back-pressure mid-burst
        @(negedge clk);
        set_req(1, 32'h5550, 4, 8);
        #1;
        serve(0, 1'b1, 0);

        // Reset in the middle of a burst, then a normal burst
        @(negedge clk);
        set_req(1, 32'h7700, 4, 8);
        #1;
        serve(0, 1'b0, 2);
        @(negedge clk);
        set_req(0, 32'h0ABC, 3, 3);
        #1;
        serve(1, 1'b0, 0);

        // Zero length means one beat
        @(negedge clk);
        set_req(1, 32'h0040, 0, 8);
        #1;
        serve(0, 1'b0, 0);

        // Randomized bursts and contests
        for (int it = 0; it < 25; it++) begin
            int r;
            r = $urandom_range(3, 1);
            @(negedge clk);
            if (r[0]) set_req(0, $urandom, $urandom_range(15), $urandom_range(15));
            if (r[1]) set_req(1, $urandom, $urandom_range(15), $urandom_range(15));
            #1;
            while (req_m[0] || req_m[1]) serve($urandom_range(3), 1'($urandom_range(1)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
